// File: rtl/mem_responder.sv
// mem_responder: single-port word memory behind a simple request/response handshake.
//
// A request (READ, WRITE, READ2, ALLOC) is taken when the responder is idle, powered
// and execute is high. Each request walks IDLE -> BUSY -> RESP -> IDLE. The RAM is
// accessed in BUSY, and read results are registered on the BUSY -> RESP edge. The
// ALLOC opcode writes to a bump allocator pointer (free_addr). That pointer saturates
// at the last word and raises a sticky full flag.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   power             gate for accepting new requests
//   execute           request strobe
//   func              opcode: 00 READ, 01 WRITE, 10 READ2, 11 ALLOC
//   address1/2        primary / secondary word address
//   write_data        write payload (WRITE, ALLOC)
//   read_data1/2      registered read results, held until the next read completes
//   is_ready          high only while idle
//   free_addr         next address ALLOC will write
//   full              sticky: allocator has written the last word
module mem_responder #(
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 10,
    parameter int FREE_BASE = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              power,
    input  logic              execute,
    input  logic [1:0]        func,
    input  logic [ADDR_W-1:0] address1,
    input  logic [ADDR_W-1:0] address2,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic              is_ready,
    output logic [ADDR_W-1:0] free_addr,
    output logic              full
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    localparam logic [1:0] FUNC_READ  = 2'b00;
    localparam logic [1:0] FUNC_WRITE = 2'b01;
    localparam logic [1:0] FUNC_READ2 = 2'b10;
    localparam logic [1:0] FUNC_ALLOC = 2'b11;

    typedef enum logic [1:0] {
        StInit,
        StIdle,
        StBusy,
        StResp
    } state_t;

    state_t state;

    // Request fields latched on acceptance.
    logic [1:0]        func_q;
    logic [ADDR_W-1:0] addr1_q;
    logic [ADDR_W-1:0] addr2_q;
    logic [DATA_W-1:0] wdata_q;

    // Storage is deliberately not reset so preloaded images survive rst.
    logic [DATA_W-1:0] mem [DEPTH];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;

    // An ALLOC while full turns into a no-op write but keeps the normal handshake.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr1_q;
        if (state == StBusy) begin
            if (func_q == FUNC_WRITE) begin
                mem_we = 1'b1;
            end else if (func_q == FUNC_ALLOC && !full) begin
                mem_we    = 1'b1;
                mem_waddr = free_addr;
            end
        end
    end

    // The write commits on the BUSY -> RESP edge. A reset that lands during BUSY
    // forces the state to INIT before that edge, so the pending write is dropped.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= wdata_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StInit;
            is_ready   <= 1'b0;
            read_data1 <= '0;
            read_data2 <= '0;
            free_addr  <= ADDR_W'(FREE_BASE);
            full       <= 1'b0;
            func_q     <= FUNC_READ;
            addr1_q    <= '0;
            addr2_q    <= '0;
            wdata_q    <= '0;
        end else begin
            case (state)
                StInit: begin
                    state    <= StIdle;
                    is_ready <= 1'b1;
                end
                StIdle: begin
                    if (execute && power) begin
                        func_q   <= func;
                        addr1_q  <= address1;
                        addr2_q  <= address2;
                        wdata_q  <= write_data;
                        state    <= StBusy;
                        is_ready <= 1'b0;
                    end
                end
                StBusy: begin
                    state <= StResp;
                    case (func_q)
                        FUNC_READ: begin
                            read_data1 <= mem[addr1_q];
                        end
                        FUNC_READ2: begin
                            read_data1 <= mem[addr1_q];
                            read_data2 <= mem[addr2_q];
                        end
                        FUNC_ALLOC: begin
                            // Pointer stops on the last word; full marks it consumed.
                            if (!full) begin
                                if (free_addr == LAST_ADDR) begin
                                    full <= 1'b1;
                                end else begin
                                    free_addr <= free_addr + 1'b1;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
                StResp: begin
                    state    <= StIdle;
                    is_ready <= 1'b1;
                end
                default: begin
                    state    <= StInit;
                    is_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder. It uses a default-parameter instance (a_*) and a
// small instance (b_*, ADDR_W = 4, FREE_BASE = 14) for allocator exhaustion.
module tb_mem_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Default instance
    logic        a_power = 1'b1, a_execute = 1'b0;
    logic [1:0]  a_func = 2'b00;
    logic [9:0]  a_addr1 = '0, a_addr2 = '0;
    logic [63:0] a_wdata = '0;
    logic [63:0] a_rd1, a_rd2;
    logic        a_ready, a_full;
    logic [9:0]  a_free;

    // Small instance
    logic        b_power = 1'b1, b_execute = 1'b0;
    logic [1:0]  b_func = 2'b00;
    logic [3:0]  b_addr1 = '0, b_addr2 = '0;
    logic [63:0] b_wdata = '0;
    logic [63:0] b_rd1, b_rd2;
    logic        b_ready, b_full;
    logic [3:0]  b_free;

    int total = 0;
    int bad = 0;

    mem_responder dut_a (
        .clk(clk), .rst(rst), .power(a_power), .execute(a_execute), .func(a_func),
        .address1(a_addr1), .address2(a_addr2), .write_data(a_wdata),
        .read_data1(a_rd1), .read_data2(a_rd2), .is_ready(a_ready),
        .free_addr(a_free), .full(a_full)
    );

    mem_responder #(.DATA_W(64), .ADDR_W(4), .FREE_BASE(14)) dut_b (
        .clk(clk), .rst(rst), .power(b_power), .execute(b_execute), .func(b_func),
        .address1(b_addr1), .address2(b_addr2), .write_data(b_wdata),
        .read_data1(b_rd1), .read_data2(b_rd2), .is_ready(b_ready),
        .free_addr(b_free), .full(b_full)
    );

    // Drive one request from a negedge with is_ready high. Returns the number of sampled
    // cycles with is_ready low, capped at 10. The task ends on a negedge with execute
    // dropped.
    task automatic req_a(input logic [1:0] f, input logic [9:0] x1, input logic [9:0] x2,
                         input logic [63:0] wd, output int nlow);
        a_func = f; a_addr1 = x1; a_addr2 = x2; a_wdata = wd; a_execute = 1'b1;
        nlow = 0;
        @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (a_ready) break;
            nlow++;
        end
        a_execute = 1'b0;
    endtask

    task automatic req_b(input logic [1:0] f, input logic [3:0] x1, input logic [3:0] x2,
                         input logic [63:0] wd, output int nlow);
        b_func = f; b_addr1 = x1; b_addr2 = x2; b_wdata = wd; b_execute = 1'b1;
        nlow = 0;
        @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (b_ready) break;
            nlow++;
        end
        b_execute = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got %b want 0", a_ready); end
        total++; if (a_rd1 !== 64'd0 || a_rd2 !== 64'd0) begin bad++; $display("FAIL rst_rdata got %h/%h want 0/0", a_rd1, a_rd2); end
        total++; if (a_free !== 10'd16) begin bad++; $display("FAIL rst_free got %0d want 16", a_free); end
        total++; if (a_full !== 1'b0) begin bad++; $display("FAIL rst_full got %b want 0", a_full); end
        total++; if (b_free !== 4'd14) begin bad++; $display("FAIL rst_free_b got %0d want 14", b_free); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got %b want 1", a_ready); end
        total++; if (a_free !== 10'd16 || a_full !== 1'b0) begin bad++; $display("FAIL rst_release_alloc got %0d/%b want 16/0", a_free, a_full); end
    endtask

    task automatic test_write_read2();
        int n;
        req_a(2'b01, 10'd5, 10'd0, 64'hDEAD, n);
        total++; if (n !== 2) begin bad++; $display("FAIL write_low_cycles got %0d want 2", n); end
        total++; if (a_rd1 !== 64'd0 || a_rd2 !== 64'd0) begin bad++; $display("FAIL write_keeps_rdata got %h/%h want 0/0", a_rd1, a_rd2); end
        req_a(2'b10, 10'd5, 10'd5, 64'd0, n);
        total++; if (n !== 2) begin bad++; $display("FAIL read2_low_cycles got %0d want 2", n); end
        total++; if (a_rd1 !== 64'hDEAD || a_rd2 !== 64'hDEAD) begin bad++; $display("FAIL read2_same got %h/%h want dead/dead", a_rd1, a_rd2); end
    endtask

    task automatic test_read_single();
        int n;
        req_a(2'b01, 10'd7, 10'd0, 64'h1234, n);
        req_a(2'b00, 10'd7, 10'd5, 64'd0, n);
        total++; if (a_rd1 !== 64'h1234) begin bad++; $display("FAIL read_rd1 got %h want 1234", a_rd1); end
        total++; if (a_rd2 !== 64'hDEAD) begin bad++; $display("FAIL read_keeps_rd2 got %h want dead", a_rd2); end
    endtask

    task automatic test_alloc();
        int n;
        for (int i = 1; i <= 3; i++) begin
            req_a(2'b11, 10'd0, 10'd0, 64'(i), n);
            total++; if (a_free !== 10'(16 + i)) begin bad++; $display("FAIL alloc_free_%0d got %0d want %0d", i, a_free, 16 + i); end
        end
        total++; if (a_rd1 !== 64'h1234 || a_full !== 1'b0) begin bad++; $display("FAIL alloc_keeps got rd1=%h full=%b want 1234/0", a_rd1, a_full); end
        req_a(2'b10, 10'd16, 10'd18, 64'd0, n);
        total++; if (a_rd1 !== 64'd1 || a_rd2 !== 64'd3) begin bad++; $display("FAIL alloc_read2 got %h/%h want 1/3", a_rd1, a_rd2); end
        req_a(2'b00, 10'd17, 10'd0, 64'd0, n);
        total++; if (a_rd1 !== 64'd2) begin bad++; $display("FAIL alloc_mid got %h want 2", a_rd1); end
    endtask

    task automatic test_full();
        int n;
        req_b(2'b11, 4'd0, 4'd0, 64'hA1, n);
        total++; if (b_free !== 4'd15 || b_full !== 1'b0) begin bad++; $display("FAIL full_1 got %0d/%b want 15/0", b_free, b_full); end
        req_b(2'b11, 4'd0, 4'd0, 64'hA2, n);
        total++; if (b_free !== 4'd15 || b_full !== 1'b1) begin bad++; $display("FAIL full_2 got %0d/%b want 15/1", b_free, b_full); end
        req_b(2'b11, 4'd0, 4'd0, 64'hA3, n);
        total++; if (n !== 2) begin bad++; $display("FAIL full_3_handshake got %0d want 2", n); end
        req_b(2'b11, 4'd0, 4'd0, 64'hA4, n);
        total++; if (b_free !== 4'd15 || b_full !== 1'b1) begin bad++; $display("FAIL full_4 got %0d/%b want 15/1", b_free, b_full); end
        req_b(2'b10, 4'd14, 4'd15, 64'd0, n);
        total++; if (b_rd1 !== 64'hA1 || b_rd2 !== 64'hA2) begin bad++; $display("FAIL full_contents got %h/%h want a1/a2", b_rd1, b_rd2); end
    endtask

    task automatic test_power();
        int n;
        req_a(2'b01, 10'd9, 10'd0, 64'hAAAA, n);
        a_power = 1'b0;
        a_func = 2'b01; a_addr1 = 10'd9; a_wdata = 64'hBBBB; a_execute = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL power_hold_%0d got %b want 1", i, a_ready); end
        end
        a_execute = 1'b0; a_power = 1'b1;
        req_a(2'b00, 10'd9, 10'd0, 64'd0, n);
        total++; if (a_rd1 !== 64'hAAAA) begin bad++; $display("FAIL power_ram got %h want aaaa", a_rd1); end
        // Raise power with execute pending; the request should be taken on the next edge.
        a_power = 1'b0;
        a_func = 2'b01; a_addr1 = 10'd9; a_wdata = 64'hBBBB; a_execute = 1'b1;
        @(negedge clk);
        a_power = 1'b1;
        @(negedge clk);
        total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL power_accept got %b want 0", a_ready); end
        a_execute = 1'b0;
        a_power = 1'b0;  // dropping power mid-flight must not abort
        @(negedge clk);
        @(negedge clk);
        total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL power_inflight_ready got %b want 1", a_ready); end
        a_power = 1'b1;
        req_a(2'b00, 10'd9, 10'd0, 64'd0, n);
        total++; if (a_rd1 !== 64'hBBBB) begin bad++; $display("FAIL power_write got %h want bbbb", a_rd1); end
    endtask

    task automatic test_back_to_back();
        logic [5:0] seen;
        a_func = 2'b00; a_addr1 = 10'd5; a_execute = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen[i] = a_ready;
        end
        a_execute = 1'b0;
        // Expected ready samples, oldest first: 0,0,1,0,0,1.
        total++; if (seen !== 6'b100100) begin bad++; $display("FAIL b2b_ready got %b want 100100", seen); end
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        total++; if (a_ready !== 1'b1 || a_rd1 !== 64'hDEAD) begin bad++; $display("FAIL b2b_end got %b/%h want 1/dead", a_ready, a_rd1); end
    endtask

    task automatic test_reset_abort();
        int n;
        req_a(2'b01, 10'd20, 10'd0, 64'h1111, n);
        req_a(2'b10, 10'd20, 10'd5, 64'd0, n);
        req_a(2'b11, 10'd0, 10'd0, 64'h77, n);
        a_func = 2'b01; a_addr1 = 10'd20; a_wdata = 64'h2222; a_execute = 1'b1;
        @(posedge clk);
        a_execute = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL abort_ready got %b want 0", a_ready); end
        total++; if (a_rd1 !== 64'd0 || a_rd2 !== 64'd0) begin bad++; $display("FAIL abort_rdata got %h/%h want 0/0", a_rd1, a_rd2); end
        total++; if (a_free !== 10'd16) begin bad++; $display("FAIL abort_free got %0d want 16", a_free); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL abort_release got %b want 1", a_ready); end
        req_a(2'b00, 10'd20, 10'd0, 64'd0, n);
        total++; if (a_rd1 !== 64'h1111) begin bad++; $display("FAIL abort_old_value got %h want 1111", a_rd1); end
    endtask

    initial begin
        test_reset();
        test_write_read2();
        test_read_single();
        test_alloc();
        test_full();
        test_power();
        test_back_to_back();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
